// File: rtl/sfp_pkg.sv
// Shared definitions for the accumulate + ReLU post-processing sequencer.
// Holds the state encoding, the default tile geometry and a width helper.
package sfp_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_RD   = 3'd2,
    S_WAIT = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam int KIJ_NUM_DEF = 9;
  localparam int O_NPIX_DEF  = 16;

  // Minimum 1 bit so single-entry counters still have a register.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/lat_pipe.sv
// 1-bit delay line of DEPTH registers with synchronous flush; aligns an
// enable with a fixed SRAM read latency.
module lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d = DEPTH'({sr_q, d_i});
    if (flush_i) sr_d = '0;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) sr_q <= '0;
    else         sr_q <= sr_d;
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/sfp_seq_ctrl.sv
// Per-pixel sequencer: clear accumulators, stream kij partial sums from psum
// SRAM, align acc_en to the read latency, then write the ReLU result.
module sfp_seq_ctrl
  import sfp_pkg::*;
#(
  parameter int KIJ_NUM = KIJ_NUM_DEF,
  parameter int O_NPIX  = O_NPIX_DEF,
  parameter int PSUM_AW = 11,
  parameter int OUT_AW  = 4,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               psum_ren,
  output logic [PSUM_AW-1:0] psum_addr,
  output logic               acc_clr,
  output logic               acc_en,
  output logic               out_wen,
  output logic [OUT_AW-1:0]  out_addr
);

  localparam int KW = clog2(KIJ_NUM);
  localparam int PW = clog2(O_NPIX);
  localparam logic [KW-1:0]      KIJ_LAST  = KW'(KIJ_NUM - 1);
  localparam logic [PW-1:0]      PIX_LAST  = PW'(O_NPIX - 1);
  localparam logic               WAIT_LAST = 1'(RD_LAT - 1);
  localparam logic [PSUM_AW-1:0] STEP      = PSUM_AW'(O_NPIX);

  if (KIJ_NUM < 1 || KIJ_NUM > 16) begin : g_bad_kij
    $error("sfp_seq_ctrl: KIJ_NUM out of range 1..16");
  end
  if (O_NPIX < 1 || O_NPIX > 64) begin : g_bad_npix
    $error("sfp_seq_ctrl: O_NPIX out of range 1..64");
  end
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
    $error("sfp_seq_ctrl: RD_LAT must be 1 or 2");
  end
  if (KIJ_NUM * O_NPIX > (1 << PSUM_AW)) begin : g_bad_aw
    $error("sfp_seq_ctrl: KIJ_NUM*O_NPIX exceeds psum address space");
  end

  state_e             state_q, state_d;
  logic [KW-1:0]      kij_q, kij_d;
  logic [PW-1:0]      opix_q, opix_d;
  logic [PSUM_AW-1:0] base_q, base_d;
  logic               wcnt_q, wcnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               ren_q, ren_d, clr_q, clr_d, wen_q, wen_d;
  logic [PSUM_AW-1:0] paddr_q, paddr_d;
  logic [OUT_AW-1:0]  oaddr_q, oaddr_d;

  // Outputs are computed for the cycle being entered and registered, so the
  // address for read k is base (k*O_NPIX, kept as a running sum) plus opix.
  always_comb begin
    state_d = state_q;
    kij_d   = kij_q;
    opix_d  = opix_q;
    base_d  = base_q;
    wcnt_d  = wcnt_q;
    clr_d   = 1'b0;
    ren_d   = 1'b0;
    paddr_d = '0;
    wen_d   = 1'b0;
    oaddr_d = '0;
    done_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      kij_d   = '0;
      opix_d  = '0;
      base_d  = '0;
      wcnt_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_CLR;
          opix_d  = '0;
          clr_d   = 1'b1;
        end
        S_CLR: begin
          state_d = S_RD;
          kij_d   = '0;
          base_d  = '0;
          ren_d   = 1'b1;
          paddr_d = PSUM_AW'(opix_q);
        end
        S_RD: if (kij_q == KIJ_LAST) begin
          state_d = S_WAIT;
          wcnt_d  = 1'b0;
        end else begin
          kij_d   = kij_q + 1'b1;
          base_d  = base_q + STEP;
          ren_d   = 1'b1;
          paddr_d = base_q + STEP + PSUM_AW'(opix_q);
        end
        S_WAIT: if (wcnt_q == WAIT_LAST) begin
          state_d = S_WR;
          wen_d   = 1'b1;
          oaddr_d = OUT_AW'(opix_q);
        end else begin
          wcnt_d  = wcnt_q + 1'b1;
        end
        S_WR: if (opix_q == PIX_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_CLR;
          opix_d  = opix_q + 1'b1;
          clr_d   = 1'b1;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = !(state_d == S_IDLE || state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      kij_q   <= '0;
      opix_q  <= '0;
      base_q  <= '0;
      wcnt_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ren_q   <= 1'b0;
      paddr_q <= '0;
      clr_q   <= 1'b0;
      wen_q   <= 1'b0;
      oaddr_q <= '0;
    end else begin
      state_q <= state_d;
      kij_q   <= kij_d;
      opix_q  <= opix_d;
      base_q  <= base_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ren_q   <= ren_d;
      paddr_q <= paddr_d;
      clr_q   <= clr_d;
      wen_q   <= wen_d;
      oaddr_q <= oaddr_d;
    end
  end

  lat_pipe #(.DEPTH(RD_LAT)) u_lat_pipe (
    .clk    (clk),
    .rst_ni (reset),
    .flush_i(abort),
    .d_i    (ren_q),
    .q_o    (acc_en)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign psum_ren  = ren_q;
  assign psum_addr = paddr_q;
  assign acc_clr   = clr_q;
  assign out_wen   = wen_q;
  assign out_addr  = oaddr_q;

endmodule

// File: tb/tb_sfp_seq_ctrl.sv
// Scoreboard bench: a tile-level model queues the expected outputs of every
// busy/done cycle; a negedge monitor pops and compares them.
module tb_sfp_seq_ctrl;

  typedef struct packed {
    logic        clr;
    logic        ren;
    logic [10:0] paddr;
    logic        en;
    logic        wen;
    logic [3:0]  oaddr;
    logic        done;
    logic        busy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst_n = 2'b11;
  logic [1:0] start = 2'b00;
  logic [1:0] abort = 2'b00;

  int vec = 0;
  int fails = 0;

  // Geometry of the two instances: defaults, and a small rd_lat=2 tile.
  int K [2] = '{9, 4};
  int NP[2] = '{16, 2};
  int L [2] = '{1, 2};

  exp_t q[2][$];

  logic        a_busy, a_done, a_ren, a_clr, a_en, a_wen;
  logic [10:0] a_paddr;
  logic [3:0]  a_oaddr;
  logic        b_busy, b_done, b_ren, b_clr, b_en, b_wen;
  logic [10:0] b_paddr;
  logic [3:0]  b_oaddr;

  sfp_seq_ctrl dut_a (
    .clk(clk), .reset(rst_n[0]), .start(start[0]), .abort(abort[0]),
    .busy(a_busy), .done(a_done), .psum_ren(a_ren), .psum_addr(a_paddr),
    .acc_clr(a_clr), .acc_en(a_en), .out_wen(a_wen), .out_addr(a_oaddr)
  );

  sfp_seq_ctrl #(.KIJ_NUM(4), .O_NPIX(2), .PSUM_AW(11), .OUT_AW(4), .RD_LAT(2)) dut_b (
    .clk(clk), .reset(rst_n[1]), .start(start[1]), .abort(abort[1]),
    .busy(b_busy), .done(b_done), .psum_ren(b_ren), .psum_addr(b_paddr),
    .acc_clr(b_clr), .acc_en(b_en), .out_wen(b_wen), .out_addr(b_oaddr)
  );

  function automatic obs_t get_obs(int id);
    if (id == 0) return {a_clr, a_ren, a_paddr, a_en, a_wen, a_oaddr, a_done, a_busy};
    return {b_clr, b_ren, b_paddr, b_en, b_wen, b_oaddr, b_done, b_busy};
  endfunction

  // Tile model: start sampled in cycle T; each pixel takes K+L+2 cycles
  // (clear, K reads, L drain, write), then one done cycle.
  task automatic gen_tile(int id, int t);
    int per, n, p, r;
    exp_t e;
    per = K[id] + L[id] + 2;
    n   = NP[id] * per;
    for (int rel = 0; rel <= n; rel++) begin
      e.cyc = t + 1 + rel;
      e.o   = '0;
      if (rel == n) begin
        e.o.done = 1'b1;
      end else begin
        p = rel / per;
        r = rel % per;
        e.o.busy = 1'b1;
        e.o.clr  = (r == 0);
        e.o.ren  = (r >= 1 && r <= K[id]);
        if (e.o.ren) e.o.paddr = 11'((r - 1) * NP[id] + p);
        e.o.en   = (r >= 1 + L[id] && r <= K[id] + L[id]);
        e.o.wen  = (r == K[id] + L[id] + 1);
        if (e.o.wen) e.o.oaddr = 4'(p);
      end
      q[id].push_back(e);
    end
  endtask

  task automatic trim(int id, int last_cyc);
    while (q[id].size() > 0 && q[id][$].cyc > last_cyc) void'(q[id].pop_back());
  endtask

  task automatic check_cycle(int id);
    obs_t a;
    exp_t e;
    logic act;
    a = get_obs(id);
    act = a.busy | a.done | a.clr | a.ren | a.en | a.wen;
    while (q[id].size() > 0 && q[id][0].cyc < cyc) begin
      e = q[id].pop_front();
      vec++; fails++;
      $display("FAIL dut%0d missed_cycle expected cyc=%0d now=%0d", id, e.cyc, cyc);
    end
    if (q[id].size() > 0 && q[id][0].cyc == cyc) begin
      e = q[id].pop_front();
      if (!e.o.ren) a.paddr = '0;
      if (!e.o.wen) a.oaddr = '0;
      vec++;
      if (a !== e.o) begin
        fails++;
        $display("FAIL dut%0d cycle_outputs cyc=%0d got clr=%b ren=%b paddr=%0d en=%b wen=%b oaddr=%0d done=%b busy=%b required clr=%b ren=%b paddr=%0d en=%b wen=%b oaddr=%0d done=%b busy=%b",
                 id, cyc, a.clr, a.ren, a.paddr, a.en, a.wen, a.oaddr, a.done, a.busy,
                 e.o.clr, e.o.ren, e.o.paddr, e.o.en, e.o.wen, e.o.oaddr, e.o.done, e.o.busy);
      end
    end else if (act) begin
      vec++; fails++;
      $display("FAIL dut%0d spurious_activity cyc=%0d got %h required idle", id, cyc, a);
    end
  endtask

  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) check_cycle(id);
  end

  task automatic drive(int id, logic s, logic ab);
    start[id] = s;
    abort[id] = ab;
  endtask

  task automatic check_zero(int id, string name);
    obs_t a;
    a = get_obs(id);
    vec++;
    if (a !== '0) begin
      fails++;
      $display("FAIL dut%0d %s got %h required 0", id, name, a);
    end
  endtask

  // abort_at: tile-relative cycle of an abort pulse (<=0 for none).
  // glitch: scatter start pulses over busy cycles and the done cycle.
  task automatic run_tile(int id, int abort_at, bit glitch);
    int t, n;
    n = NP[id] * (K[id] + L[id] + 2);
    @(negedge clk);
    t = cyc;
    drive(id, 1'b1, 1'b0);
    gen_tile(id, t);
    $display("tile dut%0d start_cyc=%0d abort_at=%0d glitch=%0d", id, t, abort_at, glitch);
    for (int i = 1; i <= n + 1; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        drive(id, 1'b0, 1'b1);
        trim(id, cyc);
        @(negedge clk);
        drive(id, 1'b0, 1'b0);
        return;
      end
      drive(id, glitch && ((i == n + 1) || ($urandom % 4 == 0)), 1'b0);
    end
    @(negedge clk);
    drive(id, 1'b0, 1'b0);
  endtask

  task automatic reset_mid_wait();
    int t, per, wc;
    per = K[0] + L[0] + 2;
    @(negedge clk);
    t = cyc;
    drive(0, 1'b1, 1'b0);
    gen_tile(0, t);
    @(negedge clk);
    drive(0, 1'b0, 1'b0);
    wc = t + 1 + 3 * per + K[0] + 1;
    while (cyc < wc) @(negedge clk);
    #2 rst_n[0] = 1'b0;
    trim(0, cyc);
    #1 check_zero(0, "async_reset_mid_wait");
    $display("reset dut0 asserted in cyc=%0d", cyc);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n[0] = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int n;
    #1 rst_n = 2'b00;
    repeat (3) @(negedge clk);
    check_zero(0, "reset_state");
    check_zero(1, "reset_state");
    #2 rst_n = 2'b11;
    repeat (2) @(negedge clk);

    run_tile(0, -1, 1'b0);
    run_tile(1, -1, 1'b0);
    run_tile(0, 7, 1'b0);
    run_tile(0, -1, 1'b1);

    @(negedge clk);
    drive(0, 1'b1, 1'b1);
    $display("idle dut0 start+abort together cyc=%0d", cyc);
    @(negedge clk);
    drive(0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    reset_mid_wait();
    run_tile(0, -1, 1'b0);

    for (int it = 0; it < 8; it++) begin
      for (int id = 0; id < 2; id++) begin
        n = NP[id] * (K[id] + L[id] + 2);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        run_tile(id, ($urandom % 3 == 0) ? int'($urandom_range(1, n)) : -1, 1'($urandom % 2));
      end
    end

    repeat (4) @(negedge clk);
    for (int id = 0; id < 2; id++) begin
      vec++;
      if (q[id].size() != 0) begin
        fails++;
        $display("FAIL dut%0d leftover_expected got %0d entries required 0", id, q[id].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule

// File: doc/sfp_seq_ctrl.md
Name: sfp_seq_ctrl

Overview:
- Sequencer for the output-stationary accumulate + ReLU post-processing stage.
- For each output pixel it:
  - clears the column accumulators;
  - streams that pixel's partial sums for every kernel position (kij) out of psum SRAM;
  - pulses accumulate-enable aligned to SRAM read latency;
  - writes the ReLU result to output SRAM.
- Sits between the top-level core controller (start/done) and the psum SRAM, accumulator datapath and output SRAM.

Parameters:
- kij_num, 9: kernel positions accumulated per output pixel (3x3 conv); legal range 1..16.
- o_npix, 16: output pixels per tile; legal range 1..64.
- psum_aw, 11: psum SRAM address width.
- out_aw, 4: output SRAM address width.
- rd_lat, 1: psum SRAM read latency in cycles; legal values 1 or 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to process a full tile; sampled only in IDLE.
- abort  in  1  synchronous abort; overrides everything except reset.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse after the last output write.
- psum_ren  out  1  psum SRAM read enable.
- psum_addr  out  psum_aw  psum read address = kij*o_npix + opix.
- acc_clr  out  1  synchronous clear of all column accumulators.
- acc_en  out  1  accumulator adds the current psum SRAM data this cycle.
- out_wen  out  1  output SRAM write enable; data is the datapath's ReLU of the accumulator.
- out_addr  out  out_aw  output write address = opix.

Behaviour:
- Reset (reset=0, async): state=IDLE; opix=0, kij=0; every output 0; latency shift register 0.
- All outputs are registered (Moore); nothing is combinational from inputs.
- FSM states: IDLE, CLR, RD, WAIT, WR, DONE.
- IDLE:
  - start=1 -> CLR next cycle; opix<=0.
  - start=0 -> remain in IDLE.
- CLR (1 cycle): acc_clr=1; kij<=0; -> RD.
- RD (kij_num cycles):
  - psum_ren=1, psum_addr=kij*o_npix+opix; kij increments each cycle.
  - After kij=kij_num-1 -> WAIT.
- acc_en:
  - psum_ren delayed by exactly rd_lat cycles through a shift register.
  - Therefore asserted for kij_num cycles, starting rd_lat cycles after the first read.
- WAIT (rd_lat cycles): no reads; the final acc_en cycles drain through the shift register. -> WR.
- WR (1 cycle):
  - out_wen=1, out_addr=opix.
  - The accumulator already holds the full sum, so no acc_en overlaps WR.
  - opix==o_npix-1 -> DONE; otherwise opix++ and -> CLR.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- Latency:
  - Per pixel = 1 + kij_num + rd_lat + 1 cycles (12 at defaults).
  - Tile = o_npix*(kij_num+rd_lat+2) cycles of busy, then 1 cycle of done (192+1 at defaults).
- start:
  - Ignored in every state except IDLE, including DONE.
  - start held high re-triggers only from IDLE.
- abort=1 in any state:
  - Next state is IDLE; psum_ren, acc_en, out_wen are forced 0 from the next cycle.
  - Shift register is flushed; no done pulse; opix/kij are cleared.
  - abort together with start in IDLE: stay in IDLE.
- Asynchronous reset mid-tile: immediate return to reset values; no partial write completes after reset deasserts.
- Address arithmetic:
  - kij*o_npix+opix is computed in psum_aw bits.
  - kij_num*o_npix must be <= 2**psum_aw; this is an elaboration-time check.
  - Counters are sized clog2 of their limit and never wrap past their limit.

Decomposition:
- Shared package (sfp_pkg): state encoding constants, default kij_num/o_npix, and a clog2 helper function.
- Sub-module lat_pipe (parameter depth = rd_lat, 1-bit shift register with synchronous flush) generates acc_en. It is reusable for other SRAM-latency alignment.
- The address multiply is replaced by a running base register (+o_npix per kij step), so no multiplier is needed.

Test Plan:
1. Defaults, start pulse at cycle 0:
   - acc_clr at cycle 1.
   - psum_ren cycles 2-10 with addrs 0,16,32,...,128.
   - acc_en cycles 3-11.
   - out_wen cycle 12 with out_addr 0.
   - Next acc_clr at cycle 13.
   - Last out_wen (addr 15) at cycle 192; done at cycle 193; busy low at 193.
2. Pixel 5 window: the psum_ren address sequence is 5,21,...,133, and out_addr=5 on its out_wen. Checks both addressing terms.
3. rd_lat=2, kij_num=4, o_npix=2:
   - acc_en lags psum_ren by 2 cycles.
   - WR follows 2 WAIT cycles; total busy = 16, then done.
4. abort at cycle 7 (mid-RD, pixel 0):
   - From cycle 8: psum_ren=acc_en=out_wen=0, busy=0; no done pulse.
   - A new start then restarts at opix 0, addr 0.
5. start re-asserted during busy and during DONE: ignored. Only one tile runs, and exactly one done pulse occurs.
6. reset driven low asynchronously mid-WAIT: all outputs 0 immediately, without waiting for a clock edge. After release, IDLE is held until start.
